// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
// A bundle is four 16-bit slots of PC, instruction and recovery PC plus four prediction bits.
package fetch_pkg;

    localparam int unsigned SLOT_W   = 16;
    localparam int unsigned SLOTS    = 4;
    localparam int unsigned BUNDLE_W = 3 * SLOTS * SLOT_W + SLOTS;  // 196

    localparam logic [SLOT_W-1:0] NOP_INST = 16'h0000;

    typedef struct packed {
        logic [SLOTS*SLOT_W-1:0] pc;
        logic [SLOTS*SLOT_W-1:0] inst;
        logic [SLOTS*SLOT_W-1:0] recv_pc;
        logic [SLOTS-1:0]        pred;
    } bundle_t;

    // What decode sees when nothing is valid: all NOP slots, everything else zero.
    function automatic bundle_t nop_bundle();
        bundle_t b;
        b         = '0;
        b.inst    = {SLOTS{NOP_INST}};
        return b;
    endfunction

endpackage

// File: rtl/fetch_dec_queue_mem.sv
// DEPTH x BUNDLE_W storage for the fetch/decode queue.
// One synchronous write port, one asynchronous read port; contents are not reset.
module fetch_dec_queue_mem
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PTR_W-1:0]    waddr,
    input  logic [BUNDLE_W-1:0] wdata,
    input  logic [PTR_W-1:0]    raddr,
    output logic [BUNDLE_W-1:0] rdata
);

    logic [BUNDLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_dec_queue.sv
// Decoupling queue between the fetch packer and the 4-wide decoder, flushed on mispredict.
// Optional same-cycle bypass on an empty queue: define FETCH_DEC_QUEUE_BYPASS_EN.
module fetch_dec_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_vld,
    output logic             fetch_rdy,
    input  logic [63:0]      pc_in,
    input  logic [63:0]      inst_in,
    input  logic [63:0]      recv_pc_in,
    input  logic [3:0]       pred_in,
    input  logic             flush,
    input  logic             dec_rdy,
    output logic             dec_vld,
    output logic [63:0]      pc_out,
    output logic [63:0]      inst_out,
    output logic [63:0]      recv_pc_out,
    output logic [3:0]       pred_out,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             empty, full, push, pop, bypass;
    bundle_t          wr_bundle, head_bundle, out_bundle;

    assign wr_bundle = '{pc: pc_in, inst: inst_in, recv_pc: recv_pc_in, pred: pred_in};

    assign empty     = (cnt == '0);
    assign full      = (cnt == FULL_CNT);
    assign fetch_rdy = !full;

`ifdef FETCH_DEC_QUEUE_BYPASS_EN
    assign bypass = empty && fetch_vld && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign dec_vld = !empty || bypass;
    assign pop     = !empty && dec_rdy;
    // A bypassed bundle taken by decode this cycle never enters storage.
    assign push    = fetch_vld && !full && !(bypass && dec_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    fetch_dec_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (wr_bundle),
        .raddr (rd_ptr),
        .rdata (head_bundle)
    );

    always_comb begin
        out_bundle = nop_bundle();
        if (bypass) begin
            out_bundle = wr_bundle;
        end else if (!empty) begin
            out_bundle = head_bundle;
        end
    end

    assign pc_out      = out_bundle.pc;
    assign inst_out    = out_bundle.inst;
    assign recv_pc_out = out_bundle.recv_pc;
    assign pred_out    = out_bundle.pred;
    assign count       = cnt;

endmodule

// File: tb/tb_fetch_dec_queue.sv
// Directed self-checking bench for fetch_dec_queue (DEPTH=4).
// Covers push/pop, full refusal, steady streaming across wrap, flush, async reset and bypass.
module tb_fetch_dec_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic [63:0] pc_in, inst_in, recv_pc_in;
    logic [3:0]  pred_in;
    logic        flush;
    logic        dec_rdy;
    logic        dec_vld;
    logic [63:0] pc_out, inst_out, recv_pc_out;
    logic [3:0]  pred_out;
    logic [2:0]  count;

    int n_asrt = 0;
    int n_fail = 0;
    int sb[$];

    always #5 clk = ~clk;

    fetch_dec_queue #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_vld   (fetch_vld),
        .fetch_rdy   (fetch_rdy),
        .pc_in       (pc_in),
        .inst_in     (inst_in),
        .recv_pc_in  (recv_pc_in),
        .pred_in     (pred_in),
        .flush       (flush),
        .dec_rdy     (dec_rdy),
        .dec_vld     (dec_vld),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .recv_pc_out (recv_pc_out),
        .pred_out    (pred_out),
        .count       (count)
    );

    // Bundle k: pc slots k*16+0..3, distinctive non-NOP instructions, recovery = ~pc.
    function automatic bundle_t mk(int k);
        bundle_t     b;
        logic [15:0] base;
        logic [15:0] kk;
        base      = 16'(k * 16);
        kk        = 16'(k);
        b.pc      = {base, base + 16'd1, base + 16'd2, base + 16'd3};
        b.inst    = {16'hA000 | kk, 16'hB000 | kk, 16'hC000 | kk, 16'hD000 | kk};
        b.recv_pc = ~b.pc;
        b.pred    = 4'(k);
        return b;
    endfunction

    task automatic drive(int k);
        bundle_t b;
        b          = mk(k);
        pc_in      = b.pc;
        inst_in    = b.inst;
        recv_pc_in = b.recv_pc;
        pred_in    = b.pred;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(string tag, int k);
        bundle_t b;
        b = mk(k);
        chk({tag, "_pc"}, pc_out, b.pc);
        chk({tag, "_inst"}, inst_out, b.inst);
        chk({tag, "_recv"}, recv_pc_out, b.recv_pc);
        chk({tag, "_pred"}, 64'(pred_out), 64'(b.pred));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        fetch_vld = 1'b0;
        flush     = 1'b0;
        dec_rdy   = 1'b0;
        drive(0);
        #3;
        chk("rst_dec_vld", 64'(dec_vld), 64'd0);
        chk("rst_fetch_rdy", 64'(fetch_rdy), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pc_out", pc_out, 64'd0);
        chk("rst_inst_out", inst_out, 64'd0);
        chk("rst_recv_out", recv_pc_out, 64'd0);
        chk("rst_pred_out", 64'(pred_out), 64'd0);
        #9;
        rst_n = 1'b1;

        // Single push, decoder stalled
        drive(1);
        fetch_vld = 1'b1;
        #1;
        chk("in_pc_literal", pc_in, 64'h0010_0011_0012_0013);
`ifdef FETCH_DEC_QUEUE_BYPASS_EN
        chk("bypass_stall_vld", 64'(dec_vld), 64'd1);
        chk("bypass_stall_pc", pc_out, 64'h0010_0011_0012_0013);
`else
        chk("latency_vld", 64'(dec_vld), 64'd0);
        chk("latency_inst", inst_out, 64'd0);
`endif
        cyc();
        fetch_vld = 1'b0;
        chk("push1_vld", 64'(dec_vld), 64'd1);
        chk("push1_count", 64'(count), 64'd1);
        chk_head("push1", 1);

        // Fill to DEPTH
        fetch_vld = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            drive(k);
            cyc();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_rdy", 64'(fetch_rdy), 64'd0);
        drive(5);
        cyc();
        chk("full_refuse_count", 64'(count), 64'd4);
        chk_head("full_refuse_head", 1);

        // Full with push and pop: only the pop happens
        dec_rdy = 1'b1;
        cyc();
        fetch_vld = 1'b0;
        dec_rdy   = 1'b0;
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_rdy", 64'(fetch_rdy), 64'd1);
        chk_head("full_pop_head", 2);
        sb = '{2, 3, 4};

        // Down to two entries
        dec_rdy = 1'b1;
        cyc();
        void'(sb.pop_front());
        chk("two_count", 64'(count), 64'd2);

        // Streaming push+pop for 10 cycles across pointer wrap
        fetch_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(10 + i);
            #1;
            chk_head("stream_head", sb[0]);
            cyc();
            void'(sb.pop_front());
            sb.push_back(10 + i);
            chk("stream_count", 64'(count), 64'd2);
        end
        fetch_vld = 1'b0;
        dec_rdy   = 1'b0;
        chk_head("stream_tail", sb[0]);

        // Third entry, then flush with concurrent push and pop
        drive(30);
        fetch_vld = 1'b1;
        cyc();
        chk("pre_flush_count", 64'(count), 64'd3);
        drive(31);
        flush   = 1'b1;
        dec_rdy = 1'b1;
        cyc();
        flush     = 1'b0;
        fetch_vld = 1'b0;
        dec_rdy   = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_vld", 64'(dec_vld), 64'd0);
        chk("flush_inst", inst_out, 64'd0);
        chk("flush_rdy", 64'(fetch_rdy), 64'd1);
        cyc();
        chk("flush_nolost_count", 64'(count), 64'd0);
        chk("flush_nolost_vld", 64'(dec_vld), 64'd0);

        // Flush on an empty queue is harmless
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_empty_count", 64'(count), 64'd0);

        // Pointers restart at zero after flush
        fetch_vld = 1'b1;
        drive(40);
        cyc();
        drive(41);
        cyc();
        fetch_vld = 1'b0;
        chk("post_flush_count", 64'(count), 64'd2);
        chk_head("post_flush_head", 40);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 64'(dec_vld), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_pc", pc_out, 64'd0);
        #2;
        rst_n = 1'b1;
        cyc();
        fetch_vld = 1'b1;
        drive(50);
        cyc();
        fetch_vld = 1'b0;
        chk("post_rst_count", 64'(count), 64'd1);
        chk_head("post_rst_head", 50);
        dec_rdy = 1'b1;
        cyc();
        dec_rdy = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_vld", 64'(dec_vld), 64'd0);

`ifdef FETCH_DEC_QUEUE_BYPASS_EN
        // Same-cycle bypass, consumed without storage
        drive(60);
        fetch_vld = 1'b1;
        dec_rdy   = 1'b1;
        #1;
        chk("bypass_vld", 64'(dec_vld), 64'd1);
        chk_head("bypass", 60);
        flush = 1'b1;
        #1;
        chk("bypass_flush_vld", 64'(dec_vld), 64'd0);
        flush = 1'b0;
        cyc();
        fetch_vld = 1'b0;
        dec_rdy   = 1'b0;
        chk("bypass_count", 64'(count), 64'd0);
        chk("bypass_after_vld", 64'(dec_vld), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_dec_queue.md
Name: fetch_dec_queue

Overview:
- Decoupling buffer between the fetch output packer and the 4-wide decoder.
- Each entry holds one fetch bundle:
  - four 16-bit PCs
  - four 16-bit instructions
  - four 16-bit recovery PCs
  - four prediction bits
- Absorbs decoder stalls with a valid/ready handshake. Drops all buffered bundles on a branch-mispredict flush.
- Presents the oldest bundle to decode with a 1-cycle minimum latency.

Parameters:
- DEPTH, 4, number of bundle entries; power of two, 2..8.
- PTR_W, 2, log2(DEPTH); derived, not overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- fetch_vld  input  1  fetch presents a bundle this cycle
- fetch_rdy  output  1  queue can accept a bundle (not full)
- pc_in  input  64  {pc0,pc1,pc2,pc3}, slot 0 in [63:48]
- inst_in  input  64  instructions, same slot order; 16'h0000 = NOP
- recv_pc_in  input  64  per-slot recovery PC
- pred_in  input  4  per-slot taken prediction, slot 0 = bit 3
- flush  input  1  mispredict/recovery: discard all entries
- dec_rdy  input  1  decoder accepts head bundle this cycle
- dec_vld  output  1  head bundle valid
- pc_out  output  64  head bundle PCs
- inst_out  output  64  head bundle instructions
- recv_pc_out  output  64  head bundle recovery PCs
- pred_out  output  4  head bundle predictions
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset state:
  - wr_ptr=0, rd_ptr=0, count=0.
  - dec_vld=0, fetch_rdy=1.
  - pc_out, inst_out, recv_pc_out, pred_out = 0.
  - Storage array contents are not reset.
- Push: fetch_vld && fetch_rdy. Writes the bundle at wr_ptr; wr_ptr+1 mod DEPTH.
- Pop: dec_vld && dec_rdy. rd_ptr+1 mod DEPTH.
- fetch_rdy = (count != DEPTH). Depends on registered state only, with no combinational path from dec_rdy.
  - When full, a push is refused even if a pop occurs the same cycle.
- dec_vld = (count != 0).
- Head outputs: driven from entry[rd_ptr] when count != 0, else all zeros. Empty outputs must read as NOP bundles.
- Latency: a bundle pushed in cycle N is visible at the outputs in cycle N+1.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
- Pointer wrap: natural PTR_W-bit rollover. count disambiguates full from empty.
- Flush has priority over push and pop in the same cycle. Next cycle: count=0, rd_ptr=wr_ptr=0, dec_vld=0, fetch_rdy=1. The concurrent push is discarded.
- Flush while empty: no effect beyond pointer reset.
- Reset asserted mid-operation: immediate return to the reset state, independent of clk.
- Bundle contents are stored and returned bit-exact. No per-slot interpretation.

Optional Feature:
- Macro: FETCH_DEC_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and fetch_vld, the outputs show the incoming bundle combinationally and dec_vld=1.
  - If dec_rdy is also 1, the bundle is consumed without being written and count stays 0.
  - flush suppresses the bypass: dec_vld=0.
- Not defined: strict 1-cycle latency as above.

Decomposition:
- Shared package (fetch_pkg):
  - BUNDLE_W = 196
  - SLOT_W = 16
  - NOP_INST = 16'h0000
  - a packed bundle typedef {pc, inst, recv_pc, pred}
- Sub-module: fetch_dec_queue_mem, a DEPTH x BUNDLE_W register array with one write port and one asynchronous read port.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset, then push bundle pc_in=64'h0010_0011_0012_0013 with dec_rdy=0 → next cycle dec_vld=1, pc_out equal to the input, count=1.
- Push 4 bundles with dec_rdy=0 → count=4, fetch_rdy=0. A fifth fetch_vld is ignored, count stays 4, and the head is still the first bundle.
- Full queue with fetch_vld=1 and dec_rdy=1 for one cycle → only the pop occurs, count=3, then fetch_rdy=1.
- Count=2, hold fetch_vld=1 and dec_rdy=1 for 10 cycles → count stays 2. Bundles exit in order across pointer wrap, matched against a scoreboard.
- Count=3, assert flush together with fetch_vld=1 and dec_rdy=1 → next cycle count=0, dec_vld=0, inst_out=0, fetch_rdy=1. No bundle is lost into a later cycle.
- Assert rst_n=0 mid-cycle with count=2 → dec_vld and count drop to 0 before the next clk edge. With FETCH_DEC_QUEUE_BYPASS_EN defined, push on an empty queue with dec_rdy=1 → same-cycle dec_vld=1, count remains 0.
